// File: rtl/pc_unit.sv
// Program counter with trap/eret mode FSM and a circular return-address stack.
// Every output is registered; a control input reaches pc_out one cycle later. No backpressure: stall holds state and drops the request.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(32'h0000_0080),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    input  logic             trap,
    input  logic             eret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] epc_out,
    output logic             in_trap,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);

    localparam int unsigned      PW      = $clog2(RAS_DEPTH);
    localparam int unsigned      CW      = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } mode_t;

    mode_t            state;
    mode_t            state_nxt;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;
    logic [PW-1:0]    ras_ptr_nxt;
    logic [PW-1:0]    ras_ptr_dec;
    logic [CW-1:0]    ras_cnt;
    logic [CW-1:0]    ras_cnt_nxt;
    logic [WIDTH-1:0] ras_top;

    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] epc_nxt;
    logic [WIDTH-1:0] pc_seq;
    logic             push;
    logic             pop;
    logic             err_nxt;

    // ras_ptr is the next write slot; the power-of-two depth lets it wrap
    // freely, so a push when full lands on the oldest entry.
    assign pc_seq      = pc_out + STEP_W;
    assign ras_ptr_dec = ras_ptr - PW'(1);
    assign ras_top     = ras_mem[ras_ptr_dec];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (trap) begin
            state_nxt = TRAP;
        end else if (eret && state == TRAP) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        in_trap = (state == TRAP);
    end

    // Next-PC selection in strict priority order; reset is applied in the
    // register process below.
    always_comb begin
        pc_nxt  = pc_out;
        epc_nxt = epc_out;
        push    = 1'b0;
        pop     = 1'b0;
        err_nxt = 1'b0;
        if (trap) begin
            pc_nxt = TRAP_VEC;
            if (state == RUN) begin
                epc_nxt = pc_out;
            end
        end else if (eret && state == TRAP) begin
            pc_nxt = epc_out;
        end else if (stall) begin
            pc_nxt = pc_out;
        end else if (ret) begin
            if (ras_cnt != '0) begin
                pc_nxt = ras_top;
                pop    = 1'b1;
            end else begin
                pc_nxt  = pc_seq;
                err_nxt = 1'b1;
            end
        end else if (call) begin
            pc_nxt = jump_target;
            push   = 1'b1;
        end else if (jump) begin
            pc_nxt = jump_target;
        end else if (branch_taken) begin
            pc_nxt = branch_target;
        end else begin
            pc_nxt = pc_seq;
        end
    end

    always_comb begin
        ras_ptr_nxt = ras_ptr;
        ras_cnt_nxt = ras_cnt;
        if (push) begin
            ras_ptr_nxt = ras_ptr + PW'(1);
            if (ras_cnt != DEPTH_C) begin
                ras_cnt_nxt = ras_cnt + CW'(1);
            end
        end else if (pop) begin
            ras_ptr_nxt = ras_ptr_dec;
            ras_cnt_nxt = ras_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out    <= RESET_VEC;
            epc_out   <= '0;
            ras_ptr   <= '0;
            ras_cnt   <= '0;
            ras_full  <= 1'b0;
            ras_empty <= 1'b1;
            ras_err   <= 1'b0;
        end else begin
            pc_out    <= pc_nxt;
            epc_out   <= epc_nxt;
            ras_ptr   <= ras_ptr_nxt;
            ras_cnt   <= ras_cnt_nxt;
            ras_full  <= (ras_cnt_nxt == DEPTH_C);
            ras_empty <= (ras_cnt_nxt == '0);
            ras_err   <= err_nxt;
        end
    end

    // Stack storage needs no reset: a zero count makes its contents invisible.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_mem[ras_ptr] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized control traffic,
// checked each cycle against a queue-based reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump, call, ret, trap, eret;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, epc_out;
    logic        in_trap, ras_full, ras_empty, ras_err;

    logic        reset8, stall8, branch8, jump8, call8, ret8, trap8, eret8;
    logic [7:0]  bt8, jt8, pc8, epc8;
    logic        in_trap8, full8, empty8, err8;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] m_pc, m_epc;
    logic        m_trap, m_err;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .call(call), .jump_target(jump_target),
        .ret(ret), .trap(trap), .eret(eret),
        .pc_out(pc_out), .epc_out(epc_out), .in_trap(in_trap),
        .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    pc_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .stall(stall8),
        .branch_taken(branch8), .branch_target(bt8),
        .jump(jump8), .call(call8), .jump_target(jt8),
        .ret(ret8), .trap(trap8), .eret(eret8),
        .pc_out(pc8), .epc_out(epc8), .in_trap(in_trap8),
        .ras_full(full8), .ras_empty(empty8), .ras_err(err8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: the stack is a queue whose back is the newest return address.
    task automatic model_step();
        if (reset) begin
            m_pc = 32'd0; m_epc = 32'd0; m_trap = 1'b0; m_err = 1'b0;
            m_ras.delete();
        end else begin
            m_err = 1'b0;
            if (trap) begin
                if (!m_trap) m_epc = m_pc;
                m_pc   = 32'h80;
                m_trap = 1'b1;
            end else if (eret && m_trap) begin
                m_pc   = m_epc;
                m_trap = 1'b0;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else begin
                    m_pc  = m_pc + 32'd1;
                    m_err = 1'b1;
                end
            end else if (call) begin
                m_ras.push_back(m_pc + 32'd1);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
                m_pc = jump_target;
            end else if (jump) m_pc = jump_target;
            else if (branch_taken) m_pc = branch_target;
            else m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("pc", pc_out, m_pc);
        chk("epc", epc_out, m_epc);
        chk("in_trap", 32'(in_trap), 32'(m_trap));
        chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
        chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        chk("ras_err", 32'(ras_err), 32'(m_err));
    endtask

    task automatic set_idle();
        reset = 0; stall = 0; branch_taken = 0; jump = 0; call = 0;
        ret = 0; trap = 0; eret = 0; branch_target = 0; jump_target = 0;
    endtask

    initial begin
        set_idle();
        reset  = 1;
        reset8 = 1; stall8 = 0; branch8 = 0; jump8 = 0; call8 = 0;
        ret8 = 0; trap8 = 0; eret8 = 0; bt8 = 0; jt8 = 0;
        m_pc = 0; m_epc = 0; m_trap = 0; m_err = 0;

        // reset for two cycles, then sequential counting
        tick(); tick();
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        reset = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq", pc_out, 32'(i));
        end

        // call / ret round trip from pc 10
        jump = 1; jump_target = 32'd10; tick(); jump = 0;
        call = 1; jump_target = 32'd40; tick(); call = 0;
        chk("call_pc", pc_out, 32'd40);
        tick(); chk("call_seq1", pc_out, 32'd41);
        tick(); chk("call_seq2", pc_out, 32'd42);
        ret = 1; tick(); ret = 0;
        chk("ret_pc", pc_out, 32'd11);
        chk("ret_empty", 32'(ras_empty), 32'd1);

        // five calls overflow a 4-deep stack, then five rets
        reset = 1; tick(); reset = 0;
        for (int i = 1; i <= 5; i++) begin
            call = 1; jump_target = 32'(i * 100); tick();
            chk("ovf_call", pc_out, 32'(i * 100));
        end
        call = 0;
        chk("ovf_full", 32'(ras_full), 32'd1);
        ret = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf_ret", pc_out, 32'(401 - 100 * i));
        end
        tick();
        chk("ret_empty_pc", pc_out, 32'd102);
        chk("ret_empty_err", 32'(ras_err), 32'd1);
        ret = 0;
        tick();
        chk("err_pulse_end", 32'(ras_err), 32'd0);

        // trap overrides stall, eret restores
        jump = 1; jump_target = 32'd7; tick(); jump = 0;
        stall = 1; trap = 1; tick(); stall = 0; trap = 0;
        chk("trap_pc", pc_out, 32'h80);
        chk("trap_epc", epc_out, 32'd7);
        chk("trap_mode", 32'(in_trap), 32'd1);
        tick();
        eret = 1; tick(); eret = 0;
        chk("eret_pc", pc_out, 32'd7);
        chk("eret_mode", 32'(in_trap), 32'd0);

        // jump beats branch; stall drops branch
        branch_taken = 1; branch_target = 32'd20; jump = 1; jump_target = 32'd30;
        tick(); jump = 0;
        chk("jmp_vs_br", pc_out, 32'd30);
        stall = 1; tick(); stall = 0; branch_taken = 0;
        chk("stall_br", pc_out, 32'd30);

        // 32-bit wrap, then reset while trapped
        jump = 1; jump_target = 32'hFFFF_FFFF; tick(); jump = 0;
        tick(); chk("wrap32", pc_out, 32'd0);
        trap = 1; tick(); trap = 0;
        stall = 1; reset = 1; tick(); stall = 0; reset = 0;
        chk("rst_trap_pc", pc_out, 32'd0);
        chk("rst_trap_mode", 32'(in_trap), 32'd0);

        // 8-bit instance: wrap, trap, reset in trap
        reset8 = 0; jump8 = 1; jt8 = 8'd255; tick(); jump8 = 0;
        chk("w8_jump", 32'(pc8), 32'd255);
        tick(); chk("w8_wrap", 32'(pc8), 32'd0);
        trap8 = 1; tick(); trap8 = 0;
        chk("w8_trap_pc", 32'(pc8), 32'h80);
        chk("w8_trap_epc", 32'(epc8), 32'd0);
        chk("w8_in_trap", 32'(in_trap8), 32'd1);
        tick(); chk("w8_trap_seq", 32'(pc8), 32'h81);
        reset8 = 1; tick(); reset8 = 0;
        chk("w8_rst_pc", 32'(pc8), 32'd0);
        chk("w8_rst_mode", 32'(in_trap8), 32'd0);
        chk("w8_rst_empty", 32'(empty8), 32'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            trap          = ($urandom_range(0, 15) == 0);
            eret          = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 5) == 0);
            ret           = ($urandom_range(0, 3) == 0);
            call          = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom;
            jump_target   = $urandom;
            tick();
        end
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
